mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Shares the single main-memory port between two cache controllers: requester 0 is the instruction-side cache and requester 1 is the data-side cache. It accepts level-held strobe requests and grants one requester at a time, with round-robin priority on ties. It drives the memory strobe, R/W, address and write data, and times the fixed memory latency with an internal counter. When the access completes it returns read data and pulses a one-cycle ready to the granted requester.

Parameters:
AW, 16, address width
DW, 32, data width
MEM_LAT, 4, memory busy cycles after MStrobe; legal range 1..15

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high reset
Strobe0  in  1  requester 0 access request; held until Rdy0
RW0  in  1  requester 0 direction; 1 = write, 0 = read
Addr0  in  AW  requester 0 address
WData0  in  DW  requester 0 write data
Rdy0  out  1  requester 0 completion pulse
RData0  out  DW  requester 0 read data
Strobe1, RW1, Addr1, WData1, Rdy1, RData1  same as requester 0, for requester 1
MStrobe  out  1  memory start pulse
MRW  out  1  memory direction; 1 = write
MAddr  out  AW  memory address
MWData  out  DW  memory write data
MRData  in  DW  memory read data; valid on the last WAIT cycle
Busy  out  1  high in every non-IDLE state
GntId  out  1  index of the requester currently or last granted

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state = IDLE; all outputs = 0; last-served pointer = 1, so requester 0 wins the first tie.
- All outputs are registered. No combinational path from any input to any output.
- IDLE:
  - No strobe: stay in IDLE.
  - One strobe high: grant that requester.
  - Both high: grant the requester that is not the last-served one.
  - On grant: latch RW, Addr and WData of the winner into MRW, MAddr and MWData; set GntId; go to GRANT.
- GRANT (1 cycle):
  - MStrobe = 1.
  - Load counter = MEM_LAT - 1.
  - Go to WAIT.
- WAIT:
  - MStrobe = 0.
  - MRW, MAddr and MWData stay stable.
  - Counter decrements each cycle.
  - When counter = 0: capture MRData into RData of the granted requester (reads only; RData is unchanged on writes), then go to DONE.
- DONE (1 cycle):
  - Rdy of the granted requester = 1; the other Rdy stays 0.
  - Update the last-served pointer to GntId.
  - Go to IDLE.
- Latency: strobe high at a sampling edge in IDLE gives Rdy high MEM_LAT + 2 cycles later (6 cycles for MEM_LAT = 4).
- Requester contract:
  - A requester drops its strobe in the cycle after it sees Rdy.
  - A strobe still high in IDLE is treated as a new request.
  - Strobe, RW, Addr and WData changes after grant are ignored until the next IDLE.
- RData0 and RData1 hold their value until the next read completes for that requester.
- MRW, MAddr and MWData hold their last value in IDLE.
- The losing requester's strobe stays pending. It is granted at the next IDLE without re-assertion.
- reset mid-access (any state):
  - Immediate return to IDLE with all outputs cleared.
  - No Rdy is issued for the aborted access.
  - Any MStrobe in flight is dropped.
- Illegal state encoding: go to IDLE with outputs cleared.

Test Plan:
- Single read: reset, then Strobe0 = 1, RW0 = 0, Addr0 = 0x0040; memory returns MRData = 0xDEADBEEF on the last WAIT cycle -> MStrobe high 1 cycle with MAddr = 0x0040, MRW = 0; Rdy0 high exactly 6 cycles after the request edge; RData0 = 0xDEADBEEF; Rdy1 stays 0.
- Single write: Strobe1 = 1, RW1 = 1, Addr1 = 0x1234, WData1 = 0xA5A5A5A5 -> MRW = 1, MAddr = 0x1234, MWData = 0xA5A5A5A5, all stable from GRANT through WAIT; Rdy1 pulses once; RData1 unchanged.
- Tie after reset: Strobe0 and Strobe1 raised in the same cycle -> requester 0 served first (GntId = 0), then requester 1 (GntId = 1) with no extra IDLE stall; each Rdy pulses once.
- Round-robin fairness: both requesters keep re-requesting continuously for 4 accesses -> grant order 0, 1, 0, 1; Busy low for exactly one IDLE cycle between accesses.
- Late strobe change: during WAIT, change Addr0 and RW0 -> MAddr and MRW unchanged; the completed access uses the latched values.
- Reset mid-access: assert reset in the second WAIT cycle -> all outputs 0 asynchronously, state IDLE, no Rdy pulse; a new Strobe1 request afterwards completes with the normal 6-cycle latency and wins a tie against Strobe0 only if requester 0 was served last since reset.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester main-memory arbiter: instruction cache (0) and data cache (1) share one
// fixed-latency memory port, with round-robin priority on simultaneous requests.
module mem_bus_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int MEM_LAT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Strobe0,
    input  logic          RW0,
    input  logic [AW-1:0] Addr0,
    input  logic [DW-1:0] WData0,
    output logic          Rdy0,
    output logic [DW-1:0] RData0,
    input  logic          Strobe1,
    input  logic          RW1,
    input  logic [AW-1:0] Addr1,
    input  logic [DW-1:0] WData1,
    output logic          Rdy1,
    output logic [DW-1:0] RData1,
    output logic          MStrobe,
    output logic          MRW,
    output logic [AW-1:0] MAddr,
    output logic [DW-1:0] MWData,
    input  logic [DW-1:0] MRData,
    output logic          Busy,
    output logic          GntId
);

    typedef enum logic [1:0] {IDLE, GRANT, WAIT, DONE} state_e;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic            last_q;
    logic            win_d;
    logic            mstrobe_q, mrw_q, busy_q, gnt_q, rdy0_q, rdy1_q;
    logic [AW-1:0]   maddr_q;
    logic [DW-1:0]   mwdata_q, rdata0_q, rdata1_q;

    // On a tie the requester that was not served last wins.
    always_comb begin
        win_d = Strobe1;
        if (Strobe0 && Strobe1) win_d = ~last_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            mstrobe_q <= 1'b0;
            mrw_q     <= 1'b0;
            maddr_q   <= '0;
            mwdata_q  <= '0;
            busy_q    <= 1'b0;
            gnt_q     <= 1'b0;
            rdy0_q    <= 1'b0;
            rdy1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            mstrobe_q <= 1'b0;
            rdy0_q    <= 1'b0;
            rdy1_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Strobe0 || Strobe1) begin
                        gnt_q    <= win_d;
                        mrw_q    <= win_d ? RW1 : RW0;
                        maddr_q  <= win_d ? Addr1 : Addr0;
                        mwdata_q <= win_d ? WData1 : WData0;
                        busy_q   <= 1'b1;
                        state_q  <= GRANT;
                    end
                end
                GRANT: begin
                    mstrobe_q <= 1'b1;
                    cnt_q     <= CNT_INIT;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        if (!mrw_q) begin
                            if (gnt_q) rdata1_q <= MRData;
                            else       rdata0_q <= MRData;
                        end
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    rdy0_q  <= ~gnt_q;
                    rdy1_q  <= gnt_q;
                    last_q  <= gnt_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    cnt_q    <= '0;
                    mrw_q    <= 1'b0;
                    maddr_q  <= '0;
                    mwdata_q <= '0;
                    busy_q   <= 1'b0;
                    gnt_q    <= 1'b0;
                    rdata0_q <= '0;
                    rdata1_q <= '0;
                end
            endcase
        end
    end

    assign MStrobe = mstrobe_q;
    assign MRW     = mrw_q;
    assign MAddr   = maddr_q;
    assign MWData  = mwdata_q;
    assign Busy    = busy_q;
    assign GntId   = gnt_q;
    assign Rdy0    = rdy0_q;
    assign Rdy1    = rdy1_q;
    assign RData0  = rdata0_q;
    assign RData1  = rdata1_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: scoreboard of expected grants, fixed-latency memory model.
module tb_mem_bus_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MEM_LAT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          Strobe0 = 1'b0, RW0 = 1'b0, Strobe1 = 1'b0, RW1 = 1'b0;
    logic [AW-1:0] Addr0 = '0, Addr1 = '0;
    logic [DW-1:0] WData0 = '0, WData1 = '0;
    logic          Rdy0, Rdy1, MStrobe, MRW, Busy, GntId;
    logic [DW-1:0] RData0, RData1, MWData, MRData;
    logic [AW-1:0] MAddr;

    typedef struct packed {
        logic          id;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } acc_t;

    acc_t          exp_q[$];
    acc_t          cur;
    logic [DW-1:0] exp_rd0 = '0, exp_rd1 = '0;
    int            mem_cnt = 0;
    logic [AW-1:0] mem_addr = '0;
    int            total = 0;
    int            bad = 0;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset),
        .Strobe0(Strobe0), .RW0(RW0), .Addr0(Addr0), .WData0(WData0), .Rdy0(Rdy0), .RData0(RData0),
        .Strobe1(Strobe1), .RW1(RW1), .Addr1(Addr1), .WData1(WData1), .Rdy1(Rdy1), .RData1(RData1),
        .MStrobe(MStrobe), .MRW(MRW), .MAddr(MAddr), .MWData(MWData), .MRData(MRData),
        .Busy(Busy), .GntId(GntId)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return (a == 16'h0040) ? 32'hDEADBEEF : {16'hC0DE, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: read data is valid only on the last busy cycle after MStrobe.
    always @(negedge clk) begin
        if (reset) begin
            mem_cnt <= 0;
        end else if (MStrobe) begin
            mem_cnt  <= MEM_LAT;
            mem_addr <= MAddr;
        end else if (mem_cnt > 0) begin
            mem_cnt <= mem_cnt - 1;
        end
    end
    assign MRData = (mem_cnt == 1) ? mem_data(mem_addr) : 32'hBAD0BAD0;

    // Scoreboard: grant checked at MStrobe, completion checked at Rdy.
    always @(negedge clk) begin
        if (reset) begin
            exp_rd0 = '0;
            exp_rd1 = '0;
        end else begin
            if (MStrobe) begin
                chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    chk("grant_id", 64'(GntId), 64'(cur.id));
                    chk("grant_addr", 64'(MAddr), 64'(cur.addr));
                    chk("grant_rw", 64'(MRW), 64'(cur.rw));
                    chk("grant_wdata", 64'(MWData), 64'(cur.wd));
                end
            end
            if (Rdy0 || Rdy1) begin
                chk("rdy_id", 64'({Rdy1, Rdy0}), cur.id ? 64'd2 : 64'd1);
                if (!cur.rw) begin
                    if (cur.id) exp_rd1 = mem_data(cur.addr);
                    else        exp_rd0 = mem_data(cur.addr);
                end
                chk("rdata0", 64'(RData0), 64'(exp_rd0));
                chk("rdata1", 64'(RData1), 64'(exp_rd1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic id, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        acc_t r;
        r.id = id; r.rw = rw; r.addr = a; r.wd = wd;
        exp_q.push_back(r);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 64'({MStrobe, MRW, Busy, GntId, Rdy0, Rdy1}), 64'd0);
        chk({tag, "_addr"}, 64'(MAddr), 64'd0);
        chk({tag, "_wdata"}, 64'(MWData), 64'd0);
        chk({tag, "_rdata"}, {RData1, RData0}, 64'd0);
    endtask

    // lat counts edges after the request edge; first tick is the request edge itself.
    task automatic wait_rdy(input string tag, input logic id, input logic [AW-1:0] ea,
                            input logic erw, input logic [DW-1:0] ewd, input bit late_mod);
        int lat = -1;
        int nstb = 0;
        int nother = 0;
        bit got = 1'b0;
        bit granted = 1'b0;
        bit stable = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            lat++;
            if (MStrobe) begin
                nstb++;
                granted = 1'b1;
            end
            if (granted && (MAddr !== ea || MRW !== erw || MWData !== ewd)) stable = 1'b0;
            if (late_mod && lat == 2) begin
                Addr0  = 16'h0FFF;
                RW0    = 1'b1;
                WData0 = 32'hFFFF0000;
            end
            if (id ? Rdy0 : Rdy1) nother++;
            if (id ? Rdy1 : Rdy0) got = 1'b1;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(MEM_LAT + 2));
        chk({tag, "_mstrobe_cnt"}, 64'(nstb), 64'd1);
        chk({tag, "_other_rdy"}, 64'(nother), 64'd0);
        chk({tag, "_stable"}, 64'(stable), 64'd1);
        chk({tag, "_busy_at_rdy"}, 64'(Busy), 64'd0);
    endtask

    initial begin
        int seen;
        // Reset state
        repeat (2) tick();
        chk_zero("reset");
        reset = 1'b0;

        // Single read on requester 0
        Strobe0 = 1'b1; RW0 = 1'b0; Addr0 = 16'h0040; WData0 = 32'h11111111;
        push(1'b0, 1'b0, 16'h0040, 32'h11111111);
        wait_rdy("rd0", 1'b0, 16'h0040, 1'b0, 32'h11111111, 1'b0);
        Strobe0 = 1'b0;
        chk("rd0_rdata", 64'(RData0), 64'hDEADBEEF);
        tick();
        chk("rd0_rdy_pulse", 64'({Rdy0, Rdy1, Busy}), 64'd0);

        // Single write on requester 1
        Strobe1 = 1'b1; RW1 = 1'b1; Addr1 = 16'h1234; WData1 = 32'hA5A5A5A5;
        push(1'b1, 1'b1, 16'h1234, 32'hA5A5A5A5);
        wait_rdy("wr1", 1'b1, 16'h1234, 1'b1, 32'hA5A5A5A5, 1'b0);
        Strobe1 = 1'b0;
        chk("wr1_rdata_kept", 64'(RData1), 64'd0);
        tick();
        chk("wr1_hold_in_idle", {MAddr, MWData}, {16'h0, 16'h1234, 32'hA5A5A5A5});

        // Tie right after reset: requester 0 first
        reset = 1'b1;
        tick();
        reset = 1'b0;
        Strobe0 = 1'b1; RW0 = 1'b0; Addr0 = 16'h0100; WData0 = 32'h0;
        Strobe1 = 1'b1; RW1 = 1'b0; Addr1 = 16'h0200; WData1 = 32'h0;
        push(1'b0, 1'b0, 16'h0100, 32'h0);
        push(1'b1, 1'b0, 16'h0200, 32'h0);
        wait_rdy("tie_a", 1'b0, 16'h0100, 1'b0, 32'h0, 1'b0);
        Strobe0 = 1'b0;
        wait_rdy("tie_b", 1'b1, 16'h0200, 1'b0, 32'h0, 1'b0);
        Strobe1 = 1'b0;
        tick();

        // Continuous requests from both: 0,1,0,1
        Strobe0 = 1'b1; Addr0 = 16'h0A00;
        Strobe1 = 1'b1; Addr1 = 16'h0B00;
        push(1'b0, 1'b0, 16'h0A00, 32'h0);
        push(1'b1, 1'b0, 16'h0B00, 32'h0);
        push(1'b0, 1'b0, 16'h0A00, 32'h0);
        push(1'b1, 1'b0, 16'h0B00, 32'h0);
        wait_rdy("rr1", 1'b0, 16'h0A00, 1'b0, 32'h0, 1'b0);
        wait_rdy("rr2", 1'b1, 16'h0B00, 1'b0, 32'h0, 1'b0);
        wait_rdy("rr3", 1'b0, 16'h0A00, 1'b0, 32'h0, 1'b0);
        wait_rdy("rr4", 1'b1, 16'h0B00, 1'b0, 32'h0, 1'b0);
        Strobe0 = 1'b0; Strobe1 = 1'b0;
        tick();

        // Request inputs changed during WAIT are ignored
        Strobe0 = 1'b1; RW0 = 1'b0; Addr0 = 16'h0300; WData0 = 32'h12345678;
        push(1'b0, 1'b0, 16'h0300, 32'h12345678);
        wait_rdy("late", 1'b0, 16'h0300, 1'b0, 32'h12345678, 1'b1);
        Strobe0 = 1'b0; RW0 = 1'b0;
        chk("late_rdata", 64'(RData0), 64'(mem_data(16'h0300)));
        tick();

        // Reset in the second WAIT cycle
        Strobe0 = 1'b1; Addr0 = 16'h0400; WData0 = 32'h0;
        push(1'b0, 1'b0, 16'h0400, 32'h0);
        repeat (3) tick();
        chk("abort_busy_before", 64'(Busy), 64'd1);
        reset = 1'b1;
        #1;
        chk_zero("abort");
        Strobe0 = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        seen = 0;
        repeat (8) begin
            tick();
            if (Rdy0 || Rdy1 || Busy || MStrobe) seen++;
        end
        chk("abort_no_rdy", 64'(seen), 64'd0);

        Strobe1 = 1'b1; RW1 = 1'b0; Addr1 = 16'h0500; WData1 = 32'h0;
        push(1'b1, 1'b0, 16'h0500, 32'h0);
        wait_rdy("post_rst", 1'b1, 16'h0500, 1'b0, 32'h0, 1'b0);
        Strobe1 = 1'b0;
        tick();

        // Requester 0 not served since reset, so it wins this tie
        Strobe0 = 1'b1; Addr0 = 16'h0600;
        Strobe1 = 1'b1; Addr1 = 16'h0700;
        push(1'b0, 1'b0, 16'h0600, 32'h0);
        push(1'b1, 1'b0, 16'h0700, 32'h0);
        wait_rdy("tie2_a", 1'b0, 16'h0600, 1'b0, 32'h0, 1'b0);
        Strobe0 = 1'b0;
        wait_rdy("tie2_b", 1'b1, 16'h0700, 1'b0, 32'h0, 1'b0);
        Strobe1 = 1'b0;
        repeat (2) tick();

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
